// File: rtl/axilite2wbm.sv
// AXI4-Lite slave to 32-bit pipelined Wishbone master bridge.
// One transaction in flight; an optional timeout turns a hung slave into SLVERR.
module axilite2wbm #(
    parameter int ADDR_WIDTH     = 28,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [31:0]           s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [31:0]           wbm_dat_o,
    input  logic [31:0]           wbm_dat_i,
    output logic                  wbm_we_o,
    output logic [3:0]            wbm_sel_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_cyc_o,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_stall_i,
    input  logic                  wbm_err_i
);
    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_d;
    logic          last_was_write;
    logic [CW-1:0] tcnt;
    logic          grant_wr, grant_rd;
    logic          wr_ok, rd_ok;
    logic          wb_done, timeout, wr_phase;
    logic [1:0]    wb_resp;
    logic          unused_bits;

    assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[31:ADDR_WIDTH+2], s_axi_awaddr[1:0],
                           s_axi_araddr[31:ADDR_WIDTH+2], s_axi_araddr[1:0]};

    assign wr_ok    = s_axi_awvalid && s_axi_wvalid;
    assign rd_ok    = s_axi_arvalid;
    assign wb_done  = wbm_ack_i || wbm_err_i;
    assign timeout  = (TIMEOUT_CYCLES != 0) && (tcnt == TMAX);
    assign wr_phase = (state == WR_REQ) || (state == WR_WAIT);
    // err wins over a simultaneous ack; a timeout with no ack also lands here
    assign wb_resp  = (wbm_ack_i && !wbm_err_i) ? OKAY : SLVERR;

    assign wbm_cyc_o    = (state == WR_REQ) || (state == WR_WAIT) ||
                          (state == RD_REQ) || (state == RD_WAIT);
    assign wbm_stb_o    = (state == WR_REQ) || (state == RD_REQ);
    assign s_axi_bvalid = (state == WR_RESP);
    assign s_axi_rvalid = (state == RD_RESP);

    always_comb begin
        state_d       = state;
        grant_wr      = 1'b0;
        grant_rd      = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_arready = 1'b0;
        unique case (state)
            IDLE: begin
                grant_wr      = wr_ok && (!rd_ok || !last_was_write);
                grant_rd      = rd_ok && !grant_wr;
                s_axi_awready = grant_wr;
                s_axi_wready  = grant_wr;
                s_axi_arready = grant_rd;
                if (grant_wr)
                    state_d = (s_axi_wstrb == 4'h0) ? WR_RESP : WR_REQ;
                else if (grant_rd)
                    state_d = RD_REQ;
            end
            WR_REQ: begin
                if (wb_done || timeout) state_d = WR_RESP;
                else if (!wbm_stall_i)  state_d = WR_WAIT;
            end
            WR_WAIT: if (wb_done || timeout) state_d = WR_RESP;
            WR_RESP: if (s_axi_bready) state_d = IDLE;
            RD_REQ: begin
                if (wb_done || timeout) state_d = RD_RESP;
                else if (!wbm_stall_i)  state_d = RD_WAIT;
            end
            RD_WAIT: if (wb_done || timeout) state_d = RD_RESP;
            RD_RESP: if (s_axi_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_was_write <= 1'b0;
            tcnt           <= '0;
            wbm_adr_o      <= '0;
            wbm_dat_o      <= '0;
            wbm_sel_o      <= '0;
            wbm_we_o       <= 1'b0;
            s_axi_bresp    <= OKAY;
            s_axi_rresp    <= OKAY;
            s_axi_rdata    <= '0;
        end else begin
            state <= state_d;
            if (grant_wr || grant_rd) begin
                last_was_write <= grant_wr;
                tcnt           <= '0;
                wbm_we_o       <= grant_wr;
                wbm_adr_o      <= grant_wr ? s_axi_awaddr[ADDR_WIDTH+1:2]
                                           : s_axi_araddr[ADDR_WIDTH+1:2];
                wbm_sel_o      <= grant_wr ? s_axi_wstrb : 4'hF;
                if (grant_wr) begin
                    wbm_dat_o   <= s_axi_wdata;
                    s_axi_bresp <= OKAY;  // covers the zero-strobe shortcut
                end
            end
            if (wbm_cyc_o) begin
                tcnt <= tcnt + 1'b1;
                if (wb_done || timeout) begin
                    if (wr_phase) begin
                        s_axi_bresp <= wb_resp;
                    end else begin
                        s_axi_rresp <= wb_resp;
                        s_axi_rdata <= (wbm_ack_i && !wbm_err_i) ? wbm_dat_i : 32'h0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_axilite2wbm.sv
// Scoreboard bench for axilite2wbm: directed AXI-Lite traffic against a scripted
// Wishbone slave; a monitor checks WB requests and B/R responses against queues.
module tb_axilite2wbm;
    logic        clk = 0;
    logic        rst = 1;
    logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 1;
    logic        arvalid = 0, arready, rvalid, rready = 1;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
    logic [3:0]  wstrb = 0;
    logic [1:0]  bresp, rresp;
    logic [27:0] adr;
    logic [31:0] dat_o, dat_i = 0;
    logic        we, stb, cyc, ack = 0, stall = 0, err = 0;
    logic [3:0]  sel;

    axilite2wbm #(.ADDR_WIDTH(28), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_awprot(3'b000),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_arprot(3'b000),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_we_o(we),
        .wbm_sel_o(sel), .wbm_stb_o(stb), .wbm_cyc_o(cyc), .wbm_ack_i(ack),
        .wbm_stall_i(stall), .wbm_err_i(err)
    );

    always #5 clk = ~clk;

    // kind: 0 ack, 1 err, 2 ack+err, 3 never respond (late ack after cyc drops)
    typedef struct {logic [27:0] adr; logic we; logic [3:0] sel; logic [31:0] dat; int stall;} wbx_t;
    typedef struct {int stall; int kind; logic [31:0] dat;} cfg_t;
    typedef struct {logic [1:0] resp; logic [31:0] data;} rx_t;

    wbx_t       wbq[$];
    cfg_t       cfgq[$];
    logic [1:0] bq[$];
    rx_t        rq[$];
    int         checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic exp_wb(input logic [27:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d, input int st, input int kind,
                          input logic [31:0] rd);
        wbx_t x; cfg_t c;
        x.adr = a; x.we = w; x.sel = s; x.dat = d; x.stall = st;
        c.stall = st; c.kind = kind; c.dat = rd;
        wbq.push_back(x);
        cfgq.push_back(c);
    endtask

    task automatic exp_r(input logic [1:0] r, input logic [31:0] d);
        rx_t x;
        x.resp = r; x.data = d;
        rq.push_back(x);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s;
        #2;
        while (!(awready || wready) && n < 60) begin @(negedge clk); #2; n++; end
        chk("aw_hs_bound", n < 60, 1);
        chk("aw_w_together", wready, awready);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
    endtask

    task automatic axi_read(input logic [31:0] a);
        int n = 0;
        @(negedge clk);
        arvalid = 1; araddr = a;
        #2;
        while (!arready && n < 60) begin @(negedge clk); #2; n++; end
        chk("ar_hs_bound", n < 60, 1);
        @(negedge clk);
        arvalid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk); #2;
        while ((wbq.size() != 0 || bq.size() != 0 || rq.size() != 0 || cyc || bvalid || rvalid)
               && n < 100) begin
            @(negedge clk); #2; n++;
        end
        chk("idle_bound", n < 100, 1);
    endtask

    // scripted Wishbone slave, driven on the falling edge
    int   sph = 0, scnt = 0;
    cfg_t scfg;
    initial begin : slave
        forever begin
            @(negedge clk);
            ack = 0; err = 0; stall = 0; dat_i = 32'hBAD0BAD0;
            if (rst) sph = 0;
            else begin
                if (sph == 0 && cyc && stb) begin
                    if (cfgq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wb_slave_unexpected: got cycle expected none");
                    end else begin
                        scfg = cfgq.pop_front(); scnt = scfg.stall; sph = 1;
                    end
                end
                if (sph == 1) begin
                    if (scnt > 0) begin stall = 1; scnt--; end
                    else sph = 2;
                end else if (sph == 2) begin
                    if (cyc) begin
                        if (scfg.kind != 3) begin
                            ack = (scfg.kind != 1);
                            err = (scfg.kind != 0);
                            dat_i = (scfg.kind == 0) ? scfg.dat : 32'h55555555;
                            sph = 0;
                        end
                    end else begin
                        if (scfg.kind == 3) begin ack = 1; dat_i = 32'hDEAD0ACC; end
                        sph = 0;
                    end
                end
            end
        end
    end

    // monitor: compares what the DUT presents with the queued expectations
    int stbc = 0;
    initial begin : monitor
        wbx_t e;
        forever begin
            @(negedge clk); #2;
            if (rst) stbc = 0;
            else begin
                if (stb) stbc++;
                if (cyc && stb && !stall) begin
                    if (wbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wb_unexpected: got adr %h expected no request", adr);
                    end else begin
                        e = wbq.pop_front();
                        chk("wb_adr", {4'h0, adr}, {4'h0, e.adr});
                        chk("wb_we", we, e.we);
                        chk("wb_sel", sel, e.sel);
                        if (e.we) chk("wb_dat", dat_o, e.dat);
                        chk("wb_stb_cycles", stbc, e.stall + 1);
                    end
                    stbc = 0;
                end
                if (awready || arready) chk("no_overlap", cyc, 0);
                if (bvalid) begin
                    if (bq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL b_unexpected: got bresp %h expected none", bresp);
                    end else begin
                        chk("bresp", bresp, bq[0]);
                        if (bready) void'(bq.pop_front());
                    end
                end
                if (rvalid) begin
                    if (rq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL r_unexpected: got rdata %h expected none", rdata);
                    end else begin
                        chk("rresp", rresp, rq[0].resp);
                        chk("rdata", rdata, rq[0].data);
                        if (rready) void'(rq.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, saw;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_awready", awready, 0); chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);   chk("rst_rvalid", rvalid, 0);
        chk("rst_cyc", cyc, 0);         chk("rst_stb", stb, 0);
        chk("rst_we", we, 0);           chk("rst_adr", {4'h0, adr}, 0);
        chk("rst_dat", dat_o, 0);       chk("rst_sel", sel, 0);
        chk("rst_bresp", bresp, 0);     chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        @(negedge clk); rst = 0;

        // zero-wait write with cycle-exact latency
        exp_wb(28'h4, 1, 4'hF, 32'hDEADBEEF, 0, 0, 0);
        bq.push_back(2'b00);
        axi_write(32'h10, 32'hDEADBEEF, 4'hF);
        #2;
        chk("t1_T1_cyc", cyc, 1); chk("t1_T1_stb", stb, 1);
        @(negedge clk); #2;
        chk("t1_T2_stb", stb, 0); chk("t1_T2_cyc", cyc, 1); chk("t1_T2_bvalid", bvalid, 0);
        @(negedge clk); #2;
        chk("t1_T3_bvalid", bvalid, 1); chk("t1_T3_cyc", cyc, 0);
        @(negedge clk); #2;
        chk("t1_T4_bvalid", bvalid, 0);
        wait_idle();

        // read with 3 stalls, R held off for several cycles
        rready = 0;
        exp_wb(28'h8, 0, 4'hF, 0, 3, 0, 32'h12345678);
        exp_r(2'b00, 32'h12345678);
        axi_read(32'h20);
        n = 0; #2;
        while (!rvalid && n < 40) begin @(negedge clk); #2; n++; end
        chk("t2_rvalid_bound", n < 40, 1);
        repeat (5) begin chk("t2_rvalid_hold", rvalid, 1); @(negedge clk); #2; end
        @(negedge clk); rready = 1;
        wait_idle();

        // all three valid together: write, then read, then write
        exp_wb(28'h40, 1, 4'h3, 32'h11111111, 0, 0, 0);
        exp_wb(28'h81, 0, 4'hF, 0, 1, 0, 32'h600DDA7A);
        exp_wb(28'hC2, 1, 4'hC, 32'h22222222, 0, 0, 0);
        bq.push_back(2'b00); bq.push_back(2'b00);
        exp_r(2'b00, 32'h600DDA7A);
        fork
            begin
                axi_write(32'h100, 32'h11111111, 4'h3);
                axi_write(32'h308, 32'h22222222, 4'hC);
            end
            axi_read(32'h204);
        join
        wait_idle();

        // slave errors: err on write, ack+err on read
        exp_wb(28'h10, 1, 4'hF, 32'hCAFEF00D, 0, 1, 0);
        bq.push_back(2'b10);
        axi_write(32'h40, 32'hCAFEF00D, 4'hF);
        wait_idle();
        exp_wb(28'h11, 0, 4'hF, 0, 0, 2, 0);
        exp_r(2'b10, 32'h0);
        axi_read(32'h44);
        wait_idle();

        // hung slave: timeout after 8 cycles of cyc, then a normal read
        exp_wb(28'h20, 0, 4'hF, 0, 0, 3, 0);
        exp_r(2'b10, 32'h0);
        axi_read(32'h80);
        n = 0; #2;
        while (cyc && n < 30) begin @(negedge clk); #2; n++; end
        chk("t5_cyc_cycles", n, 8);
        wait_idle();
        exp_wb(28'h21, 0, 4'hF, 0, 0, 0, 32'hA5A5A5A5);
        exp_r(2'b00, 32'hA5A5A5A5);
        axi_read(32'h84);
        wait_idle();

        // zero-strobe write never touches Wishbone
        bq.push_back(2'b00);
        axi_write(32'hC, 32'hFFFFFFFF, 4'h0);
        saw = 0;
        repeat (4) begin #2; if (cyc) saw = 1; @(negedge clk); end
        chk("t6_no_cyc", saw, 0);
        wait_idle();

        // reset while in RD_WAIT drops the transaction
        exp_wb(28'h24, 0, 4'hF, 0, 0, 3, 0);
        axi_read(32'h90);
        @(negedge clk);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        #2;
        chk("t7_cyc", cyc, 0); chk("t7_stb", stb, 0);
        chk("t7_rvalid", rvalid, 0); chk("t7_rdata", rdata, 0);
        exp_wb(28'h25, 0, 4'hF, 0, 0, 0, 32'h0BADCAFE);
        exp_r(2'b00, 32'h0BADCAFE);
        axi_read(32'h94);
        wait_idle();

        chk("end_wbq", wbq.size(), 0);
        chk("end_bq", bq.size(), 0);
        chk("end_rq", rq.size(), 0);
        chk("end_cfgq", cfgq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
